// File: rtl/gpio_pio_ctrl.sv
// Avalon-MM parallel I/O: per-bit direction, synchronised inputs, edge capture and maskable irq.
// Optional per-bit input debouncer is compiled in with `define PIO_DEBOUNCE_EN.
module gpio_pio_ctrl #(
    parameter int          WIDTH           = 8,
    parameter logic [31:0] RESET_OUT       = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe
);

    logic [WIDTH-1:0] r_pioOut;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCap;
    logic [1:0]       r_edgeMode;
    logic [31:0]      r_readData;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_filtDly;
    logic [1:0]       r_startCnt;

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_wrData;
    logic [WIDTH-1:0] w_capClr;
    logic [WIDTH-1:0] w_edgeSel;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_dataRead;
    logic [31:0]      w_readMux;
    logic             w_unused;

    assign w_wrData = avs_writedata[WIDTH-1:0];
    assign w_unused = ^{avs_writedata, DEBOUNCE_CYCLES[0]};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_filtDly  <= '0;
            r_startCnt <= 2'd0;
        end else begin
            r_sync1   <= pio_in;
            r_sync2   <= r_sync1;
            r_filtDly <= w_filt;
            if (r_startCnt != 2'd3)
                r_startCnt <= r_startCnt + 2'd1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // A bit flips only after the synchronised input has disagreed for DEBOUNCE_CYCLES cycles in a row.
    for (genvar g = 0; g < WIDTH; g++) begin : g_deb
        logic [CW-1:0] r_cnt;
        logic          r_filtBit;

        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
                r_cnt     <= '0;
                r_filtBit <= 1'b0;
            end else if (r_sync2[g] == r_filtBit) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt     <= '0;
                r_filtBit <= r_sync2[g];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign w_filt[g] = r_filtBit;
    end
`else
    assign w_filt = r_sync2;
`endif

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_pioOut   <= RESET_OUT[WIDTH-1:0];
            r_dir      <= '0;
            r_irqMask  <= '0;
            r_edgeMode <= 2'b00;
        end else if (avs_write) begin
            case (avs_address)
                3'd0:    r_pioOut   <= w_wrData;
                3'd1:    r_dir      <= w_wrData;
                3'd2:    r_irqMask  <= w_wrData;
                3'd4:    r_pioOut   <= r_pioOut | w_wrData;
                3'd5:    r_pioOut   <= r_pioOut & ~w_wrData;
                3'd6:    r_edgeMode <= avs_writedata[1:0];
                default: ;
            endcase
        end
    end

    // Edges are ignored while the input pipeline refills after reset.
    always_comb begin
        w_edgeSel = '0;
        case (r_edgeMode)
            2'b00:   w_edgeSel = w_filt & ~r_filtDly;
            2'b01:   w_edgeSel = ~w_filt & r_filtDly;
            2'b10:   w_edgeSel = w_filt ^ r_filtDly;
            default: w_edgeSel = '0;
        endcase
    end

    assign w_edge   = w_edgeSel & ~r_dir & {WIDTH{r_startCnt == 2'd3}};
    assign w_capClr = (avs_write && avs_address == 3'd3) ? w_wrData : '0;

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            r_edgeCap <= '0;
        else
            r_edgeCap <= (r_edgeCap & ~w_capClr) | w_edge;
    end

    assign w_dataRead = (r_dir & r_pioOut) | (~r_dir & w_filt);

    always_comb begin
        w_readMux = '0;
        case (avs_address)
            3'd0:    w_readMux = 32'(w_dataRead);
            3'd1:    w_readMux = 32'(r_dir);
            3'd2:    w_readMux = 32'(r_irqMask);
            3'd3:    w_readMux = 32'(r_edgeCap);
            3'd6:    w_readMux = {30'd0, r_edgeMode};
            default: w_readMux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            r_readData <= '0;
        else if (avs_read)
            r_readData <= w_readMux;
    end

    assign avs_readdata = r_readData;
    assign irq          = |(r_edgeCap & r_irqMask);
    assign pio_out      = r_pioOut;
    assign pio_oe       = r_dir;

endmodule

// File: tb/tb_gpio_pio_ctrl.sv
// Directed self-checking bench for gpio_pio_ctrl (WIDTH=8, RESET_OUT=A5).
// Build with PIO_DEBOUNCE_EN defined to add the debounce scenarios (DEBOUNCE_CYCLES=4).
module tb_gpio_pio_ctrl;

    localparam int WIDTH = 8;
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rstN;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqOut;
    logic [7:0]  pin;
    logic [7:0]  pout;
    logic [7:0]  poe;

    int errors = 0;
    int checks = 0;

    gpio_pio_ctrl #(
        .WIDTH          (WIDTH),
        .RESET_OUT      (32'h0000_00A5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rstN),
        .avs_address  (addr),
        .avs_read     (rd),
        .avs_write    (wr),
        .avs_writedata(wdata),
        .avs_readdata (rdata),
        .irq          (irqOut),
        .pio_in       (pin),
        .pio_out      (pout),
        .pio_oe       (poe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic busRead(input logic [2:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rstN = 1'b0; pin = 8'h00; rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = '0;
        waitCycles(3);
        checks++; if (pout !== 8'hA5) begin errors++; $display("[TB] FAIL reset_pio_out: got %h expected a5", pout); end
        checks++; if (poe !== 8'h00) begin errors++; $display("[TB] FAIL reset_pio_oe: got %h expected 00", poe); end
        checks++; if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irqOut); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", rdata); end
        rstN = 1'b1;
        waitCycles(LAT + 2);
        busRead(3'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_read: got %h expected 0", d); end
        busRead(3'd6, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_edge_mode: got %h expected 0", d); end
    endtask

    task automatic test_data_path;
        logic [31:0] d;
        busWrite(3'd1, 32'hFFFF_FF0F);
        busWrite(3'd0, 32'h0000_003C);
        busWrite(3'd4, 32'h0000_00C0);
        busWrite(3'd5, 32'h0000_0004);
        checks++; if (pout !== 8'hF8) begin errors++; $display("[TB] FAIL set_clr_pio_out: got %h expected f8", pout); end
        checks++; if (poe !== 8'h0F) begin errors++; $display("[TB] FAIL dir_pio_oe: got %h expected 0f", poe); end
        busRead(3'd1, d);
        checks++; if (d !== 32'h0000_000F) begin errors++; $display("[TB] FAIL dir_upper_bits: got %h expected 0000000f", d); end
        pin = 8'h55;
        waitCycles(LAT + 2);
        busRead(3'd0, d);
        checks++; if (d !== 32'h0000_0058) begin errors++; $display("[TB] FAIL data_mixed_read: got %h expected 58", d); end
        waitCycles(3);
        checks++; if (rdata !== 32'h0000_0058) begin errors++; $display("[TB] FAIL readdata_hold: got %h expected 58", rdata); end
        busRead(3'd3, d);
        checks++; if (d !== 32'h0000_0050) begin errors++; $display("[TB] FAIL cap_input_only: got %h expected 50", d); end
        busWrite(3'd7, 32'hFFFF_FFFF);
        busRead(3'd7, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL addr7_read: got %h expected 0", d); end
        busRead(3'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL outset_read: got %h expected 0", d); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        busWrite(3'd1, 32'h0);
        pin = 8'h00;
        waitCycles(LAT + 2);
        busWrite(3'd3, 32'hFF);
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL cap_cleared: got %h expected 0", d); end
        busWrite(3'd6, 32'h0);
        busWrite(3'd2, 32'h1);
        pin = 8'h01;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++;
            if (irqOut !== (k == LAT)) begin
                errors++; $display("[TB] FAIL irq_latency_cycle%0d: got %b expected %b", k, irqOut, (k == LAT));
            end
        end
        busRead(3'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL cap_rise_bit0: got %h expected 1", d); end
        busWrite(3'd3, 32'h1);
        checks++; if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_clear: got %b expected 0", irqOut); end
        pin = 8'h03;
        waitCycles(LAT + 1);
        checks++; if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked: got %b expected 0", irqOut); end
        busRead(3'd3, d);
        checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL masked_capture: got %h expected 2", d); end
        busWrite(3'd3, 32'hFF);
    endtask

    task automatic test_both_edges;
        logic [31:0] d;
        busWrite(3'd6, 32'h2);
        pin = 8'h0B;
        waitCycles(LAT + 2);
        busRead(3'd3, d);
        checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL both_rise: got %h expected 8", d); end
        busWrite(3'd3, 32'h8);
        pin = 8'h03;
        waitCycles(LAT + 2);
        busRead(3'd3, d);
        checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL both_fall: got %h expected 8", d); end
        pin = 8'h0B;
        waitCycles(LAT - 1);
        busWrite(3'd3, 32'h8);
        busRead(3'd3, d);
        checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL set_wins: got %h expected 8", d); end
        busWrite(3'd3, 32'h8);
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL plain_clear: got %h expected 0", d); end
        busWrite(3'd6, 32'hFFFF_FFFF);
        pin = 8'h03;
        waitCycles(LAT + 2);
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mode_disabled: got %h expected 0", d); end
        busRead(3'd6, d);
        checks++; if (d !== 32'h3) begin errors++; $display("[TB] FAIL edge_mode_width: got %h expected 3", d); end
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] d;
        addr = 3'd1; wdata = 32'hAA; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rw_pre_write: got %h expected 0", rdata); end
        busRead(3'd1, d);
        checks++; if (d !== 32'hAA) begin errors++; $display("[TB] FAIL rw_post_write: got %h expected aa", d); end
        busWrite(3'd6, 32'h2);
        busWrite(3'd1, 32'h0);
        waitCycles(LAT + 2);
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL dir_change_no_edge: got %h expected 0", d); end
    endtask

    task automatic test_reset_hold;
        logic [31:0] d;
        busWrite(3'd1, 32'h0F);
        busRead(3'd1, d);
        pin = 8'hFF;
        rstN = 1'b0;
        @(negedge clk);
        checks++; if (poe !== 8'h00) begin errors++; $display("[TB] FAIL midreset_pio_oe: got %h expected 00", poe); end
        checks++; if (pout !== 8'hA5) begin errors++; $display("[TB] FAIL midreset_pio_out: got %h expected a5", pout); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_readdata: got %h expected 0", rdata); end
        @(negedge clk);
        rstN = 1'b1; addr = 3'd2; wdata = 32'hFF; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL startup_irq_cycle%0d: got %b expected 0", k, irqOut); end
        end
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL startup_cap: got %h expected 0", d); end
        busRead(3'd0, d);
        checks++; if (d !== 32'hFF) begin errors++; $display("[TB] FAIL startup_data: got %h expected ff", d); end
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] d;
        busWrite(3'd1, 32'h0);
        busWrite(3'd6, 32'h0);
        pin = 8'h00;
        waitCycles(20);
        busWrite(3'd3, 32'hFF);
        busWrite(3'd2, 32'h2);
        pin = 8'h02;
        waitCycles(3);
        pin = 8'h00;
        waitCycles(10);
        busRead(3'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_data: got %h expected 0", d); end
        busRead(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_cap: got %h expected 0", d); end
        pin = 8'h02;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (irqOut !== (k == 7)) begin
                errors++; $display("[TB] FAIL pulse_irq_cycle%0d: got %b expected %b", k, irqOut, (k == 7));
            end
        end
        waitCycles(3);
        pin = 8'h00;
        busRead(3'd3, d);
        checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL pulse_cap: got %h expected 2", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_path();
        test_irq();
        test_both_edges();
        test_rw_same_cycle();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`else
        test_reset_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_pio_ctrl.md
# gpio_pio_ctrl

Parametrised Avalon-MM parallel I/O peripheral for the Nios system. It succeeds the fixed-direction LED, switch, HEX and GPIO ports with one block that has a configurable width and per-bit direction. Inputs pass through a synchroniser, then edge capture, then a maskable interrupt. The block sits on the Nios data master as a slave and drives or samples board pins (GPIO_0, LEDR, SW, KEY).

## Interface
- WIDTH, 8: pin count, legal range 1..32.
- RESET_OUT, 0: reset value of the output data register.
- DEBOUNCE_CYCLES, 50000: stable-cycle count for the debouncer (1 ms at 50 MHz). Used only when debouncing is compiled in.

- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset. Synchronous, active-low.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data. Fixed read latency of 1.
- irq  out  1  level interrupt, active-high.
- pio_in  in  WIDTH  asynchronous pin inputs.
- pio_out  out  WIDTH  output data register.
- pio_oe  out  WIDTH  per-bit output enable (1 = drive).

## Operation
Register map (word addresses):
- 0 DATA
  - Read: bit i = pio_out[i] if DIR[i]=1, else the filtered input.
  - Write: loads pio_out, regardless of direction.
- 1 DIR: read/write. Drives pio_oe.
- 2 IRQ_MASK: read/write.
- 3 EDGE_CAP
  - Read: returns captured edges.
  - Write: each 1 clears the corresponding bit.
- 4 OUTSET: write only. pio_out |= wdata.
- 5 OUTCLR: write only. pio_out &= ~wdata.
- 6 EDGE_MODE: read/write, bits [1:0].
  - 00 rising.
  - 01 falling.
  - 10 both.
  - 11 capture disabled.
- 7: reads 0, writes ignored.

Input path:
- pio_in goes through a 2-flop synchroniser, then the optional debouncer, giving the filtered input.
- Edge detection compares the filtered value with its 1-cycle delayed copy.
- Edges are captured only on bits with DIR=0.

Edge detection is disabled for the first 3 cycles after reset release. This prevents spurious edges while the pipeline fills.

Interrupt:
- irq = |(EDGE_CAP & IRQ_MASK), decoded combinationally from registers.
- Masking does not stop capture.

Width rules:
- Register bits at or above WIDTH read 0 and ignore writes.
- EDGE_MODE bits [31:2] read 0.

Boundary cases:
- EDGE_CAP clear-write in the same cycle as a new edge on that bit: the bit remains set (set wins).
- Read and write to the same address in the same cycle: readdata returns the pre-write value.
- Changing DIR from output to input does not generate an edge by itself. An edge is captured only if the filtered input toggles.
- Reset asserted mid-operation clears all state within one cycle, including synchroniser and debouncer.

Reset values:
- pio_out = RESET_OUT.
- pio_oe = 0.
- IRQ_MASK = 0.
- EDGE_CAP = 0.
- EDGE_MODE = 00.
- avs_readdata = 0.
- irq = 0.

## Timing
- Register write takes effect on pio_out and pio_oe at the clock edge where avs_write is sampled.
- Read: avs_readdata is valid on the cycle after avs_read is sampled. It holds its value until the next read.
- Input latency without debounce: a pio_in change is visible in DATA reads after 2 cycles. EDGE_CAP and irq set 3 cycles after the change.
- With debounce: DEBOUNCE_CYCLES cycles are added to both latencies.
- irq deasserts the cycle after the clearing write.

## Configuration
- PIO_DEBOUNCE_EN defined
  - Each bit has its own counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The filtered bit updates only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current filtered value resets that bit's counter.
- PIO_DEBOUNCE_EN not defined
  - The filtered input equals the synchroniser output.
  - No counters are built and DEBOUNCE_CYCLES is ignored.

## Test plan
All scenarios use WIDTH=8 and no debounce unless stated.
- Reset with RESET_OUT=8'hA5 -> pio_out=A5, pio_oe=00, irq=0, read DATA=00 with pio_in=00.
- Write DIR=0F, DATA=3C; write OUTSET=C0; write OUTCLR=04 -> pio_out=F8. Read DATA with pio_in=55 -> 58.
- EDGE_MODE=00, IRQ_MASK=01, pio_in[0] rises -> EDGE_CAP=01 and irq=1 exactly 3 cycles later. Write EDGE_CAP=01 -> irq=0 the next cycle.
- EDGE_MODE=10, toggle pio_in[3] up then down, each level held 5 cycles -> EDGE_CAP=08. A clear-write in the same cycle as a new edge -> bit stays 1.
- pio_in=FF held through reset release -> no EDGE_CAP bit set and irq stays 0.
- PIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=4:
  - 3-cycle glitch on pio_in[1] -> no change to DATA or EDGE_CAP.
  - 10-cycle pulse -> EDGE_CAP=02 at cycle 7 after the rise.
